// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the memory arbiter.
// Covers FSM states, requester/owner encoding, grant bit positions and write-counter width.
package ysyx_24080014_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  // Wide enough for WR_LAT up to 15.
  localparam int unsigned WR_CNT_W = 4;

  localparam int unsigned GNT_IFU = 0;
  localparam int unsigned GNT_LSU = 1;

  function automatic arb_owner_t gnt_to_owner(input logic [1:0] gnt);
    return gnt[GNT_LSU] ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/ysyx_24080014_arb_pick.sv
// Combinational grant selection between fetch and load/store requesters.
// YSYX_24080014_ARB_RR_EN selects round-robin ties; otherwise LSU has fixed priority.
module ysyx_24080014_arb_pick (
  input  logic       ifu_req,
  input  logic       lsu_req,
  input  logic       last_own,
  output logic [1:0] gnt
);
  import ysyx_24080014_pkg::*;

`ifdef YSYX_24080014_ARB_RR_EN
  always_comb begin
    gnt = '0;
    if (ifu_req && lsu_req) begin
      // Whoever was not granted last wins the tie.
      if (last_own == OWN_LSU) gnt[GNT_IFU] = 1'b1;
      else                     gnt[GNT_LSU] = 1'b1;
    end else if (lsu_req) begin
      gnt[GNT_LSU] = 1'b1;
    end else if (ifu_req) begin
      gnt[GNT_IFU] = 1'b1;
    end
  end
`else
  logic unused_last_own;
  assign unused_last_own = last_own;

  always_comb begin
    gnt = '0;
    if (lsu_req)      gnt[GNT_LSU] = 1'b1;
    else if (ifu_req) gnt[GNT_IFU] = 1'b1;
  end
`endif

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Two-requester (fetch/LSU) single-port memory arbiter: IDLE -> ISSUE -> WAIT -> RESP.
// Define YSYX_24080014_ARB_RR_EN for round-robin tie resolution (default: LSU priority).
module ysyx_24080014_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_ready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_wdone,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  output logic [7:0]        mem_wmask,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout
);
  import ysyx_24080014_pkg::*;

  localparam logic [WR_CNT_W-1:0] WR_WAIT = WR_CNT_W'(WR_LAT - 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          own_q;
  arb_owner_t          gnt_own;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          wmask_q;
  logic [WR_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic [DATA_W-1:0]   lsu_rdata_q;
  logic [1:0]          gnt;
  logic                last_own;
  logic                accept;
  logic                in_resp;

`ifdef YSYX_24080014_ARB_RR_EN
  arb_owner_t last_q;
  assign last_own = last_q;

  // Reset value IFU makes the first tie go to LSU.
  always_ff @(posedge clk) begin
    if (rst)         last_q <= OWN_IFU;
    else if (accept) last_q <= gnt_own;
  end
`else
  assign last_own = OWN_IFU;
`endif

  ysyx_24080014_arb_pick u_pick (
    .ifu_req  (ifu_req),
    .lsu_req  (lsu_req),
    .last_own (last_own),
    .gnt      (gnt)
  );

  assign gnt_own = gnt_to_owner(gnt);
  assign accept  = (state_q == ST_IDLE) && !rst && (|gnt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      // A one-cycle write latency completes without visiting WAIT.
      ST_ISSUE: state_d = (wen_q && (WR_LAT == 1)) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (wen_q) begin
          if (cnt_q <= WR_CNT_W'(1)) state_d = ST_RESP;
        end else if (mem_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_IFU;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        own_q   <= gnt_own;
        wen_q   <= gnt[GNT_LSU] & lsu_wen;
        addr_q  <= gnt[GNT_LSU] ? lsu_addr  : ifu_addr;
        wdata_q <= gnt[GNT_LSU] ? lsu_wdata : '0;
        wmask_q <= gnt[GNT_LSU] ? lsu_wmask : '0;
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= WR_WAIT;
      end else if ((state_q == ST_WAIT) && wen_q && (cnt_q != '0)) begin
        cnt_q <= cnt_q - WR_CNT_W'(1);
      end
      // Read data lands in the owner's register and stays until its next read.
      if ((state_q == ST_WAIT) && !wen_q && mem_ready) begin
        if (own_q == OWN_LSU) lsu_rdata_q <= mem_dout;
        else                  ifu_rdata_q <= mem_dout;
      end
    end
  end

  assign ifu_ready = accept & gnt[GNT_IFU];
  assign lsu_ready = accept & gnt[GNT_LSU];

  assign in_resp    = (state_q == ST_RESP) && !rst;
  assign ifu_rvalid = in_resp && (own_q == OWN_IFU);
  assign lsu_rvalid = in_resp && (own_q == OWN_LSU) && !wen_q;
  assign lsu_wdone  = in_resp && (own_q == OWN_LSU) && wen_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rdata  = lsu_rdata_q;

  assign mem_ren   = (state_q == ST_ISSUE) && !rst && !wen_q;
  assign mem_wen   = (state_q == ST_ISSUE) && !rst && wen_q;
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_din   = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_valid = 1'b0;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Directed self-checking bench for ysyx_24080014_mem_arbiter (WR_LAT = 2).
// Drives on the falling edge and samples 1 time unit later.
module tb_ysyx_24080014_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WR_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_ready, ifu_rvalid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req, lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_ready, lsu_rvalid, lsu_wdone;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_ren, mem_wen, mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic [7:0]        mem_wmask;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ysyx_24080014_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_addr   (ifu_addr),
    .ifu_ready  (ifu_ready),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .lsu_req    (lsu_req),
    .lsu_wen    (lsu_wen),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_ready  (lsu_ready),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .lsu_wdone  (lsu_wdone),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din),
    .mem_wmask  (mem_wmask),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dout   (mem_dout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]        exp_lsu_win;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_ifu_rd;
    logic [DATA_W-1:0] exp_lsu_rd;

`ifdef YSYX_24080014_ARB_RR_EN
    exp_lsu_win = 3'b101;
`else
    exp_lsu_win = 3'b111;
`endif

    // Reset: a request during reset must not be accepted
    rst = 1'b1; ifu_req = 1'b1; ifu_addr = '0;
    lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_dout = '0;
    step(); step(); #1;
    check("rst_ifu_ready", ifu_ready, 1'b0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    check("rst_ifu_rvalid", ifu_rvalid, 1'b0);
    check("rst_lsu_wdone", lsu_wdone, 1'b0);
    check("rst_mem_strobes", {mem_ren, mem_wen}, 2'b00);
    check("rst_ifu_rdata", ifu_rdata, 32'h0);
    check("rst_lsu_rdata", lsu_rdata, 32'h0);

    // Single fetch, mem_ready two cycles after mem_ren
    step(); rst = 1'b0; ifu_addr = 32'h8000_0000; #1;
    check("fetch_ifu_ready", ifu_ready, 1'b1);
    check("fetch_lsu_ready", lsu_ready, 1'b0);
    step(); ifu_req = 1'b0; #1;
    check("fetch_mem_ren", mem_ren, 1'b1);
    check("fetch_mem_wen", mem_wen, 1'b0);
    check("fetch_raddr", mem_raddr, 32'h8000_0000);
    step(); #1;
    check("fetch_ren_once", mem_ren, 1'b0);
    check("fetch_early_rvalid", ifu_rvalid, 1'b0);
    step(); mem_ready = 1'b1; mem_dout = 32'h0000_0413; #1;
    check("fetch_wait_rvalid", ifu_rvalid, 1'b0);
    step(); mem_ready = 1'b0; mem_dout = 32'h5555_5555; #1;
    check("fetch_rvalid", ifu_rvalid, 1'b1);
    check("fetch_rdata", ifu_rdata, 32'h0000_0413);
    check("fetch_lsu_rvalid", lsu_rvalid, 1'b0);
    step(); #1;
    check("fetch_rvalid_pulse", ifu_rvalid, 1'b0);
    check("fetch_rdata_hold", ifu_rdata, 32'h0000_0413);

    // Spurious mem_ready in IDLE
    step(); mem_ready = 1'b1; mem_dout = 32'hFFFF_FFFF; #1;
    check("idle_spur_ren", mem_ren, 1'b0);
    step(); #1;
    check("idle_spur_rvalid", {ifu_rvalid, lsu_rvalid, lsu_wdone}, 3'b000);
    check("idle_spur_ifu_rdata", ifu_rdata, 32'h0000_0413);

    // Store, with spurious mem_ready during the write wait
    step(); mem_ready = 1'b0;
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; #1;
    check("store_lsu_ready", lsu_ready, 1'b1);
    step(); lsu_req = 1'b0; lsu_wdata = '0; lsu_addr = '0; lsu_wmask = '0; #1;
    check("store_mem_wen", mem_wen, 1'b1);
    check("store_mem_ren", mem_ren, 1'b0);
    check("store_waddr", mem_waddr, 32'h8000_1000);
    check("store_din", mem_din, 32'hDEAD_BEEF);
    check("store_wmask", mem_wmask, 8'h0F);
    step(); mem_ready = 1'b1; mem_dout = 32'hCAFE_F00D; #1;
    check("store_wait_wdone", lsu_wdone, 1'b0);
    check("store_wen_once", mem_wen, 1'b0);
    step(); mem_ready = 1'b0; #1;
    check("store_wdone", lsu_wdone, 1'b1);
    check("store_no_rvalid", {lsu_rvalid, ifu_rvalid}, 2'b00);
    check("store_lsu_rdata", lsu_rdata, 32'h0);
    step(); #1;
    check("store_wdone_pulse", lsu_wdone, 1'b0);

    // Contention from a fresh reset: three back-to-back transactions
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    ifu_req = 1'b1; ifu_addr = 32'h8000_2000;
    lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000; #1;
    exp_ifu_rd = '0;
    exp_lsu_rd = '0;
    for (int i = 0; i < 3; i++) begin
      d = 32'h1111_0000 + 32'(i);
      check("tie_lsu_ready", lsu_ready, exp_lsu_win[i]);
      check("tie_ifu_ready", ifu_ready, !exp_lsu_win[i]);
      step(); #1;
      check("tie_busy_ready", {ifu_ready, lsu_ready}, 2'b00);
      check("tie_raddr", mem_raddr, exp_lsu_win[i] ? 32'h8000_3000 : 32'h8000_2000);
      step(); mem_ready = 1'b1; mem_dout = d;
      step(); mem_ready = 1'b0;
      if (i == 2) begin
        ifu_req = 1'b0;
        lsu_req = 1'b0;
      end
      #1;
      if (exp_lsu_win[i]) exp_lsu_rd = d;
      else                exp_ifu_rd = d;
      check("tie_lsu_rvalid", lsu_rvalid, exp_lsu_win[i]);
      check("tie_ifu_rvalid", ifu_rvalid, !exp_lsu_win[i]);
      check("tie_lsu_rdata", lsu_rdata, exp_lsu_rd);
      check("tie_ifu_rdata", ifu_rdata, exp_ifu_rd);
      step(); #1;
    end

    // Reset mid-read, then a late mem_ready
    ifu_req = 1'b1; ifu_addr = 32'h8000_0100; #1;
    check("rstmid_ready", ifu_ready, 1'b1);
    step(); ifu_req = 1'b0; #1;
    check("rstmid_ren", mem_ren, 1'b1);
    step(); rst = 1'b1; #1;
    check("rstmid_wait_rvalid", ifu_rvalid, 1'b0);
    step(); rst = 1'b0; mem_ready = 1'b1; mem_dout = 32'hBAD0_BAD0; #1;
    check("rstmid_no_rvalid", ifu_rvalid, 1'b0);
    check("rstmid_no_ren", mem_ren, 1'b0);
    check("rstmid_rdata_clr", ifu_rdata, 32'h0);
    step(); mem_ready = 1'b0; #1;
    check("rstmid_still_no_rvalid", ifu_rvalid, 1'b0);
    check("rstmid_rdata_kept", ifu_rdata, 32'h0);
    step(); ifu_req = 1'b1; ifu_addr = 32'h8000_0004; #1;
    check("after_rst_ready", ifu_ready, 1'b1);
    step(); ifu_req = 1'b0; #1;
    check("after_rst_ren", mem_ren, 1'b1);
    check("after_rst_raddr", mem_raddr, 32'h8000_0004);
    step(); mem_ready = 1'b1; mem_dout = 32'h0010_0093;
    step(); mem_ready = 1'b0; #1;
    check("after_rst_rvalid", ifu_rvalid, 1'b1);
    check("after_rst_rdata", ifu_rdata, 32'h0010_0093);
    step(); #1;
    check("after_rst_idle", ifu_rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_mem_arbiter.md
YSYX_24080014_MEM_ARBITER -- requirements
Module: ysyx_24080014_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WR_LAT, default 2, cycles from mem_wen pulse to write completion (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ifu_req  input  1  fetch read request; ifu_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have ifu_ready  output  1  fetch request accepted this cycle; ifu_rvalid  output  1  fetch data valid pulse; ifu_rdata  output  DATA_W  fetch data.
REQ-008 SHALL have lsu_req  input  1; lsu_wen  input  1  (1=store, 0=load); lsu_addr  input  ADDR_W; lsu_wdata  input  DATA_W; lsu_wmask  input  8.
REQ-009 SHALL have lsu_ready  output  1  accept; lsu_rvalid  output  1  load data valid pulse; lsu_rdata  output  DATA_W; lsu_wdone  output  1  store complete pulse.
REQ-010 SHALL have mem_ren  output  1; mem_wen  output  1; mem_raddr/mem_waddr  output  ADDR_W; mem_din  output  DATA_W; mem_wmask  output  8; mem_valid  output  1 (driven 0 while issuing); mem_ready  input  1  read done; mem_dout  input  DATA_W  read data.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-012 In IDLE with any request, SHALL grant exactly one requester, assert its *_ready combinationally that cycle, latch addr/wdata/wmask/wen/owner, and go to ISSUE.
REQ-013 Without YSYX_24080014_ARB_RR_EN, SHALL grant LSU over IFU when both request in the same cycle.
REQ-014 *_ready SHALL be 0 in every state other than IDLE; requests outside IDLE are not accepted and need not be held by the arbiter.
REQ-015 In ISSUE, SHALL assert exactly one of mem_ren or mem_wen for exactly one cycle with latched address/data/mask, then go to WAIT.
REQ-016 In WAIT for a read, SHALL stay until mem_ready=1, register mem_dout, then go to RESP.
REQ-017 In WAIT for a write, SHALL count WR_LAT-1 cycles after ISSUE (mem_ready ignored), then go to RESP.
REQ-018 In RESP, SHALL pulse the owner's ifu_rvalid, lsu_rvalid or lsu_wdone for one cycle, with rdata stable, then return to IDLE.
REQ-019 Read latency SHALL be: accept cycle N, mem_ren at N+1, rvalid one cycle after the mem_ready cycle; minimum accept-to-accept period is 4 cycles.
REQ-020 *_rdata SHALL hold its last value until the next response to the same owner.
REQ-021 mem_ready outside WAIT, or during a write WAIT, SHALL be ignored.
REQ-022 mem_ren and mem_wen SHALL never be high together; mem outputs other than strobes are don't-care outside ISSUE but SHALL be held stable.

Reset
REQ-023 rst SHALL force IDLE, clear owner, write counter and RR pointer (next tie to LSU), and drive all ready/rvalid/wdone/mem_ren/mem_wen to 0 and rdata to 0 on the following edge.
REQ-024 rst mid-transaction SHALL abort it with no response pulse; rst takes priority over all other inputs.

Configuration
REQ-025 With YSYX_24080014_ARB_RR_EN defined, SHALL resolve simultaneous requests round-robin: the requester not granted last wins; pointer updates only on a grant.
REQ-026 Without YSYX_24080014_ARB_RR_EN, SHALL use fixed LSU priority and contain no pointer register.

Structure
REQ-027 Package ysyx_24080014_pkg SHALL hold the FSM state typedef, owner encoding (OWN_IFU, OWN_LSU) and WR_LAT counter width constant.
REQ-028 Grant selection SHALL be one combinational sub-module ysyx_24080014_arb_pick (inputs: two requests, last owner; output: grant one-hot).

Verification
REQ-029 Single fetch: ifu_req=1, ifu_addr=0x80000000, mem_ready 2 cycles after mem_ren with mem_dout=0x00000413 -> ifu_ready at N, mem_ren at N+1, ifu_rvalid with ifu_rdata=0x00000413 one cycle after mem_ready.
REQ-030 Store: lsu_req=1, lsu_wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, WR_LAT=2 -> one mem_wen pulse with those values, lsu_wdone 2 cycles later, no lsu_rvalid.
REQ-031 Contention: ifu_req and lsu_req high together for 3 transactions -> fixed: LSU,LSU,LSU; RR_EN: LSU,IFU,LSU.
REQ-032 Reset mid-read: rst in WAIT, then mem_ready -> no rvalid, FSM IDLE, next request accepted normally.
REQ-033 Spurious mem_ready=1 in IDLE and during write WAIT -> no state change, no response pulses.
